// File: rtl/arb_pkg.sv
// Shared types and constants for the two-master data bus arbiter.
package arb_pkg;

  // Hold counter width; covers MAX_HOLD up to 31.
  localparam int unsigned HOLD_W = 5;

  // FSM states; the encodings double as the owner code on the bus.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } arb_state_e;

endpackage

// File: rtl/arb_hold_counter.sv
// Saturating hold counter. It counts contended owned cycles and flags the terminal value MAX_HOLD-1.
module arb_hold_counter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_term
);

  localparam logic [HOLD_W-1:0] TERM_VAL = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] r_cnt;

  // A clear wins over an increment, so a new owner always starts at zero.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && !o_term) begin
      r_cnt <= r_cnt + HOLD_W'(1);
    end
  end

  assign o_term = (r_cnt == TERM_VAL);

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter with a bounded hold and owner lock for the shared data port.
// It selects between the CPU data master (m0) and the DMA/loader master (m1).
module data_bus_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic        m0_re,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_wdata,
  input  logic        m1_req,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic        m1_re,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wdata,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic        bus_re,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic [1:0]  owner
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       r_last_owner;   // 0 = m0, 1 = m1
  logic       w_last_owner_nxt;
  logic       w_hold_clr;
  logic       w_hold_inc;
  logic       w_hold_term;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_last_owner <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_last_owner <= w_last_owner_nxt;
    end
  end

  // Ownership decision; the hold terminal only matters when the owner is unlocked and contended.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_owner_nxt = r_last_owner;
    case (r_state)
      ST_IDLE: begin
        if (m0_req && m1_req) begin
          w_state_nxt = r_last_owner ? ST_OWN0 : ST_OWN1;
        end else if (m0_req) begin
          w_state_nxt = ST_OWN0;
        end else if (m1_req) begin
          w_state_nxt = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (m0_req) begin
          if (!m0_lock && m1_req && w_hold_term) begin
            w_state_nxt = ST_OWN1;
          end
        end else begin
          w_state_nxt = m1_req ? ST_OWN1 : ST_IDLE;
        end
        if (w_state_nxt != ST_OWN0) begin
          w_last_owner_nxt = 1'b0;
        end
      end
      ST_OWN1: begin
        if (m1_req) begin
          if (!m1_lock && m0_req && w_hold_term) begin
            w_state_nxt = ST_OWN0;
          end
        end else begin
          w_state_nxt = m0_req ? ST_OWN0 : ST_IDLE;
        end
        if (w_state_nxt != ST_OWN1) begin
          w_last_owner_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_hold_clr = (w_state_nxt != r_state);
  assign w_hold_inc = ((r_state == ST_OWN0) && m1_req) ||
                      ((r_state == ST_OWN1) && m0_req);

  arb_hold_counter #(
    .MAX_HOLD (MAX_HOLD)
  ) u_hold (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_clear (w_hold_clr),
    .i_inc   (w_hold_inc),
    .o_term  (w_hold_term)
  );

  assign m0_gnt = (r_state == ST_OWN0);
  assign m1_gnt = (r_state == ST_OWN1);
  assign owner  = 2'(r_state);

  // Bus mux: drives zeros unless the owner is actively requesting.
  always_comb begin
    bus_addr  = '0;
    bus_we    = 1'b0;
    bus_re    = 1'b0;
    bus_be    = '0;
    bus_wdata = '0;
    if ((r_state == ST_OWN0) && m0_req) begin
      bus_addr  = m0_addr;
      bus_we    = m0_we;
      bus_re    = m0_re;
      bus_be    = m0_be;
      bus_wdata = m0_wdata;
    end else if ((r_state == ST_OWN1) && m1_req) begin
      bus_addr  = m1_addr;
      bus_we    = m1_we;
      bus_re    = m1_re;
      bus_be    = m1_be;
      bus_wdata = m1_wdata;
    end
  end

  assign m0_rdata = (r_state == ST_OWN0) ? bus_rdata : '0;
  assign m1_rdata = (r_state == ST_OWN1) ? bus_rdata : '0;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Randomized and directed bench for data_bus_arbiter against a behavioural ownership model.
module tb_data_bus_arbiter;

  localparam int MAXH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_lock, m0_we, m0_re;
  logic        m1_req, m1_lock, m1_we, m1_re;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_gnt, m1_gnt;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we, bus_re;
  logic [3:0]  bus_be;
  logic [1:0]  owner;

  int n_vec = 0;
  int n_err = 0;

  // Model: who owns the bus (0 none, 1 m0, 2 m1), contended cycles already held, last master to leave.
  int  m_owner = 0;
  int  m_held  = 0;
  int  m_last  = 2;
  bit  m_valid = 1'b0;

  data_bus_arbiter #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_lock   (m0_lock),
    .m0_addr   (m0_addr),
    .m0_we     (m0_we),
    .m0_re     (m0_re),
    .m0_be     (m0_be),
    .m0_wdata  (m0_wdata),
    .m1_req    (m1_req),
    .m1_lock   (m1_lock),
    .m1_addr   (m1_addr),
    .m1_we     (m1_we),
    .m1_re     (m1_re),
    .m1_be     (m1_be),
    .m1_wdata  (m1_wdata),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_rdata  (m0_rdata),
    .m1_rdata  (m1_rdata),
    .bus_addr  (bus_addr),
    .bus_we    (bus_we),
    .bus_re    (bus_re),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit req_of(input int m);
    return (m == 1) ? m0_req : m1_req;
  endfunction

  function automatic bit lock_of(input int m);
    return (m == 1) ? m0_lock : m1_lock;
  endfunction

  // Advance the ownership model by one clock using the inputs presented at that edge.
  task automatic model_edge();
    int nxt;
    int other;
    if (!reset) begin
      m_owner = 0;
      m_held  = 0;
      m_last  = 2;
      m_valid = 1'b1;
      return;
    end
    if (m_owner == 0) begin
      if (m0_req && m1_req) nxt = (m_last == 2) ? 1 : 2;
      else if (m0_req)      nxt = 1;
      else if (m1_req)      nxt = 2;
      else                  nxt = 0;
      other = 0;
    end else begin
      other = 3 - m_owner;
      if (req_of(m_owner)) begin
        // Yield only after MAX_HOLD contended cycles and only when unlocked.
        if (req_of(other) && !lock_of(m_owner) && (m_held + 1 >= MAXH)) nxt = other;
        else nxt = m_owner;
      end else begin
        nxt = req_of(other) ? other : 0;
      end
    end
    if (nxt != m_owner) begin
      if (m_owner != 0) m_last = m_owner;
      m_held = 0;
    end else if (m_owner != 0 && req_of(other)) begin
      m_held = (m_held + 1 > MAXH - 1) ? MAXH - 1 : m_held + 1;
    end
    m_owner = nxt;
  endtask

  task automatic check_comb();
    logic [31:0] e_addr, e_wdata;
    logic [5:0]  e_ctl;
    e_addr = '0; e_wdata = '0; e_ctl = '0;
    if (m_owner == 1 && m0_req) begin
      e_addr = m0_addr; e_wdata = m0_wdata; e_ctl = {m0_we, m0_re, m0_be};
    end else if (m_owner == 2 && m1_req) begin
      e_addr = m1_addr; e_wdata = m1_wdata; e_ctl = {m1_we, m1_re, m1_be};
    end
    check_val("bus_addr", bus_addr, e_addr);
    check_val("bus_wdata", bus_wdata, e_wdata);
    check_val("bus_ctl", 32'({bus_we, bus_re, bus_be}), 32'(e_ctl));
    check_val("m0_rdata", m0_rdata, (m_owner == 1) ? bus_rdata : 32'h0);
    check_val("m1_rdata", m1_rdata, (m_owner == 2) ? bus_rdata : 32'h0);
  endtask

  // One clock: combinational check before the edge, registered check just after it.
  task automatic tick();
    #1;
    if (m_valid) check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_val("gnt", 32'({m1_gnt, m0_gnt}), 32'(m_owner));
    check_val("owner", 32'(owner), 32'(m_owner));
    check_val("one_hot_gnt", 32'(m0_gnt & m1_gnt), 32'h0);
  endtask

  initial begin
    reset = 1'b0;
    m0_req = 1'b1; m0_lock = 1'b0; m0_we = 1'b1; m0_re = 1'b0; m0_be = 4'hF;
    m0_addr = 32'h0000_1000; m0_wdata = 32'hA5A5_A5A5;
    m1_req = 1'b1; m1_lock = 1'b0; m1_we = 1'b0; m1_re = 1'b1; m1_be = 4'h3;
    m1_addr = 32'h0000_2000; m1_wdata = 32'h5A5A_5A5A;
    bus_rdata = 32'h0;

    // Reset held with both masters requesting.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'h0);
      check_val("rst_owner", 32'(owner), 32'h0);
      check_val("rst_bus_addr", bus_addr, 32'h0);
      check_val("rst_bus_we", 32'(bus_we), 32'h0);
    end

    // Release: m0 wins the first tie, then round-robin in blocks of MAXH.
    reset = 1'b1;
    for (int i = 0; i < 4 * MAXH; i++) begin
      tick();
      check_val("rr_gnt", 32'({m1_gnt, m0_gnt}), ((i / MAXH) % 2 == 0) ? 32'h1 : 32'h2);
    end

    // Both drop, then m1 alone performs a write.
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    check_val("idle_owner", 32'(owner), 32'h0);
    m1_req = 1'b1; m1_we = 1'b1; m1_re = 1'b0; m1_be = 4'hF;
    m1_addr = 32'h0000_0040; m1_wdata = 32'hDEAD_BEEF;
    tick();
    check_val("single_gnt", 32'(m1_gnt), 32'h1);
    check_val("single_addr", bus_addr, 32'h0000_0040);
    check_val("single_we", 32'(bus_we), 32'h1);
    check_val("single_wdata", bus_wdata, 32'hDEAD_BEEF);

    // Release to idle, then m0 alone, then a tie goes to m1.
    m1_req = 1'b0;
    tick();
    check_val("rel_owner", 32'(owner), 32'h0);
    check_val("rel_strobes", 32'({bus_we, bus_re}), 32'h0);
    m0_req = 1'b1;
    tick();
    check_val("m0_alone", 32'(owner), 32'h1);
    m0_req = 1'b0;
    tick();
    m0_req = 1'b1; m1_req = 1'b1;
    tick();
    check_val("tie_last_owner", 32'(owner), 32'h2);

    // Lock: m0 takes the bus, then holds it 10 cycles against m1.
    m0_req = 1'b0; m1_req = 1'b0;
    tick();
    m0_req = 1'b1;
    tick();
    m0_lock = 1'b1; m1_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("lock_hold", 32'(m0_gnt), 32'h1);
    end
    m0_lock = 1'b0;
    tick();
    check_val("lock_release", 32'({m1_gnt, m0_gnt}), 32'h2);

    // Read return to m0.
    m1_req = 1'b0;
    tick();
    bus_rdata = 32'h1234_5678;
    #1;
    check_val("rd_m0", m0_rdata, 32'h1234_5678);
    check_val("rd_m1", m1_rdata, 32'h0);

    // Randomized traffic with occasional reset, including locks from non-owners.
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(0, 99) != 0);
      m0_req    = ($urandom_range(0, 3) != 0);
      m1_req    = ($urandom_range(0, 3) != 0);
      m0_lock   = ($urandom_range(0, 7) == 0);
      m1_lock   = ($urandom_range(0, 7) == 0);
      m0_we     = 1'($urandom);
      m0_re     = 1'($urandom);
      m1_we     = 1'($urandom);
      m1_re     = 1'($urandom);
      m0_be     = 4'($urandom);
      m1_be     = 4'($urandom);
      m0_addr   = $urandom;
      m1_addr   = $urandom;
      m0_wdata  = $urandom;
      m1_wdata  = $urandom;
      bus_rdata = $urandom;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
